// File: rtl/speed_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : speed_sel_ctrl
// Purpose  : Game-speed sequencer. Produces a one-cycle movement tick at a
//            slow or fast rate and drives the registered 2:1 rate select.
//            Rate changes requested on req_sel are applied only on a tick
//            boundary, so every tick period is exactly SLOW_DIV or FAST_DIV
//            cycles. No period is ever shortened or stretched by a switch.
//            ack pulses for one cycle when the switch has taken effect.
// Ports    : clk      in   system clock, rising edge
//            rst_n    in   asynchronous active-low reset
//            req_sel  in   requested rate level (0 = slow, 1 = fast)
//            pause    in   freeze request (only with SPEED_CTRL_PAUSE_EN)
//            sel      out  current rate select (registered)
//            tick     out  one-cycle movement tick (registered)
//            ack      out  one-cycle pulse in the cycle sel changed
//            busy     out  high while a rate change is pending
//            cnt      out  current period count (observe)
// Options  : SPEED_CTRL_PAUSE_EN - when defined, pause=1 freezes the counter
//            and the FSM. When undefined, pause is not used.
// Revision : 1.0 - initial release
// ============================================================================
module speed_sel_ctrl #(
  parameter int CNT_W    = 16,
  parameter int SLOW_DIV = 1000,
  parameter int FAST_DIV = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_sel,
  input  logic             pause,
  output logic             sel,
  output logic             tick,
  output logic             ack,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_slow_term = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] c_fast_term = CNT_W'(FAST_DIV - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_sel;
  logic             r_ack;
  logic [CNT_W-1:0] w_term;
  logic             w_wrap;
  logic             w_count_en;
  logic             w_switch;

`ifdef SPEED_CTRL_PAUSE_EN
  assign w_count_en = ~pause;
`else
  // pause is kept on the port list for a uniform footprint but has no effect.
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_count_en     = 1'b1;
`endif

  // Terminal count follows the rate currently in force, so the period in
  // which a switch lands still runs at the old rate.
  assign w_term = r_sel ? c_fast_term : c_slow_term;
  assign w_wrap = (r_cnt == w_term);

  // --------------------------------------------------------------------------
  // Period counter and tick
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_count_en) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      // Frozen: hold the count, suppress ticks.
      r_tick <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Rate-switch FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Rate-switch FSM: next state and switch decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_switch     = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A request seen on a wrap edge is not applied on that edge; it
        // waits for the next boundary.
        if (w_count_en && (req_sel != r_sel)) begin
          w_next_state = ST_PEND;
        end
      end
      ST_PEND: begin
        // Withdrawal is honoured even while frozen.
        if (req_sel == r_sel) begin
          w_next_state = ST_RUN;
        end else if (w_count_en && w_wrap) begin
          w_next_state = ST_RUN;
          w_switch     = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Select register and acknowledge pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 1'b0;
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_switch;
      if (w_switch) begin
        r_sel <= ~r_sel;
      end
    end
  end

  assign sel  = r_sel;
  assign tick = r_tick;
  assign ack  = r_ack;
  assign busy = (r_state == ST_PEND);
  assign cnt  = r_cnt;

endmodule
`default_nettype wire
